// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Central hazard / flush / trap controller for a 5-stage integer pipeline.
//   Branches and jumps resolve in MEM and redirect the PC. Load-use hazards
//   insert LOAD_STALL_CYCLES bubbles. External memory waits freeze the pipe.
//   A three-state FSM sequences interrupt entry and mret exit, and blocks
//   nested traps while a handler runs.
//
// Ports
//   i_clk, i_reset            core clock, async active-high reset
//   i_rs1_id/i_rs2_id         ID source registers, with *_used_id qualifiers
//   i_mem_to_reg_exe, i_rd_exe  EXE load flag and destination register
//   i_branch_mem, i_jump_mem, i_mret_mem, i_fun3_mem  MEM control-flow info
//   i_zero_mem, i_less_mem, i_less_u_mem  ALU compare flags from MEM
//   i_interrupt, i_irq_enable level interrupt request and global enable
//   i_ext_stall               memory wait, freezes the whole pipe
//   o_pc_sel                  0 pc+4, 1 branch/jump target, 2 trap vector, 3 mepc
//   o_stall_if, o_stall_id    hold PC / hold IF/ID
//   o_flush_if_id, o_flush_id_exe, o_flush_exe_mem  bubble insertion
//   o_trap_take               one-cycle trap entry pulse
//   o_in_handler              trap in progress

module pipeline_hazard_controller #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_rs1_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_id,
  input  logic                  i_rs1_used_id,
  input  logic                  i_rs2_used_id,
  input  logic                  i_mem_to_reg_exe,
  input  logic [REG_ADDR_W-1:0] i_rd_exe,
  input  logic                  i_branch_mem,
  input  logic                  i_jump_mem,
  input  logic                  i_mret_mem,
  input  logic [2:0]            i_fun3_mem,
  input  logic                  i_zero_mem,
  input  logic                  i_less_mem,
  input  logic                  i_less_u_mem,
  input  logic                  i_interrupt,
  input  logic                  i_irq_enable,
  input  logic                  i_ext_stall,
  output logic [1:0]            o_pc_sel,
  output logic                  o_stall_if,
  output logic                  o_stall_id,
  output logic                  o_flush_if_id,
  output logic                  o_flush_id_exe,
  output logic                  o_flush_exe_mem,
  output logic                  o_trap_take,
  output logic                  o_in_handler
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PEND    = 2'd1,
    S_HANDLER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_taken;
  logic w_redirect;
  logic w_hazard_now;
  logic w_load_stall;
  logic w_irq_req;
  logic w_trap_fire;

  always_comb begin
    w_taken = 1'b0;
    case (i_fun3_mem)
      3'b000:  w_taken = i_zero_mem;
      3'b001:  w_taken = ~i_zero_mem;
      3'b100:  w_taken = i_less_mem;
      3'b101:  w_taken = ~i_less_mem;
      3'b110:  w_taken = i_less_u_mem;
      3'b111:  w_taken = ~i_less_u_mem;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_redirect   = i_jump_mem | (i_branch_mem & w_taken) | i_mret_mem;
  assign w_hazard_now = i_mem_to_reg_exe && (i_rd_exe != '0) &&
                        ((i_rs1_used_id && (i_rs1_id == i_rd_exe)) ||
                         (i_rs2_used_id && (i_rs2_id == i_rd_exe)));
  assign w_load_stall = w_hazard_now | (r_stall_cnt != '0);
  assign w_irq_req    = i_interrupt & i_irq_enable;

  // Trap is taken only while the request is still held; a withdrawn
  // request in PEND returns to IDLE without ever pulsing trap_take.
  assign w_trap_fire  = (r_state == S_PEND) & w_irq_req & ~i_ext_stall &
                        ~w_redirect & ~w_load_stall;

  // Redirect clears the counter: the stalled ID instruction is flushed.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_redirect) begin
      r_stall_cnt <= '0;
    end else if (!i_ext_stall) begin
      if (w_hazard_now && (r_stall_cnt == '0))
        r_stall_cnt <= LOAD_INIT;
      else if (r_stall_cnt != '0)
        r_stall_cnt <= r_stall_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_ext_stall) begin
      case (r_state)
        S_IDLE:    if (w_irq_req) w_state_nxt = S_PEND;
        S_PEND: begin
          if (!w_irq_req)       w_state_nxt = S_IDLE;
          else if (w_trap_fire) w_state_nxt = S_HANDLER;
        end
        S_HANDLER: if (i_mret_mem) w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_pc_sel        = 2'd0;
    o_stall_if      = 1'b0;
    o_stall_id      = 1'b0;
    o_flush_if_id   = 1'b0;
    o_flush_id_exe  = 1'b0;
    o_flush_exe_mem = 1'b0;
    o_trap_take     = 1'b0;
    o_in_handler    = (r_state == S_HANDLER);
    if (i_ext_stall) begin
      o_stall_if = 1'b1;
      o_stall_id = 1'b1;
    end else if (w_redirect) begin
      o_pc_sel        = i_mret_mem ? 2'd3 : 2'd1;
      o_flush_if_id   = 1'b1;
      o_flush_id_exe  = 1'b1;
      o_flush_exe_mem = 1'b1;
    end else if (w_trap_fire) begin
      o_pc_sel        = 2'd2;
      o_flush_if_id   = 1'b1;
      o_flush_id_exe  = 1'b1;
      o_flush_exe_mem = 1'b1;
      o_trap_take     = 1'b1;
    end else if (w_load_stall) begin
      o_stall_if     = 1'b1;
      o_stall_id     = 1'b1;
      o_flush_id_exe = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_id, rs2_id, rd_exe;
  logic       rs1_used_id, rs2_used_id, mem_to_reg_exe;
  logic       branch_mem, jump_mem, mret_mem;
  logic [2:0] fun3_mem;
  logic       zero_mem, less_mem, less_u_mem;
  logic       interrupt, irq_enable, ext_stall;
  logic [1:0] pc_sel;
  logic       stall_if, stall_id, flush_if_id, flush_id_exe, flush_exe_mem;
  logic       trap_take, in_handler;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(2)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id),
    .i_rs1_used_id(rs1_used_id), .i_rs2_used_id(rs2_used_id),
    .i_mem_to_reg_exe(mem_to_reg_exe), .i_rd_exe(rd_exe),
    .i_branch_mem(branch_mem), .i_jump_mem(jump_mem), .i_mret_mem(mret_mem),
    .i_fun3_mem(fun3_mem), .i_zero_mem(zero_mem), .i_less_mem(less_mem),
    .i_less_u_mem(less_u_mem), .i_interrupt(interrupt),
    .i_irq_enable(irq_enable), .i_ext_stall(ext_stall),
    .o_pc_sel(pc_sel), .o_stall_if(stall_if), .o_stall_id(stall_id),
    .o_flush_if_id(flush_if_id), .o_flush_id_exe(flush_id_exe),
    .o_flush_exe_mem(flush_exe_mem), .o_trap_take(trap_take),
    .o_in_handler(in_handler)
  );

  // Packed view: {pc_sel, stall_if, stall_id, flush_if_id, flush_id_exe,
  // flush_exe_mem, trap_take, in_handler}
  task automatic chk(input string tag, input logic [1:0] pc, input logic sif,
                     input logic sid, input logic f1, input logic f2,
                     input logic f3, input logic tt, input logic ih);
    logic [8:0] obs, exp;
    #1;
    obs = {pc_sel, stall_if, stall_id, flush_if_id, flush_id_exe,
           flush_exe_mem, trap_take, in_handler};
    exp = {pc, sif, sid, f1, f2, f3, tt, ih};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs1_id = 0; rs2_id = 0; rd_exe = 0; rs1_used_id = 0; rs2_used_id = 0;
    mem_to_reg_exe = 0; branch_mem = 0; jump_mem = 0; mret_mem = 0;
    fun3_mem = 0; zero_mem = 0; less_mem = 0; less_u_mem = 0;
    interrupt = 0; irq_enable = 0; ext_stall = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_hazard();
    mem_to_reg_exe = 1; rd_exe = 5; rs1_id = 5; rs1_used_id = 1;
  endtask

  //                      pc sif sid f1 f2 f3 tt ih
  initial begin
    clr();
    reset = 1;
    chk("reset_state",     0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 0;
    chk("after_release",   0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Load-use, 2 bubbles
    load_hazard();
    chk("lu_c0",           0, 1, 1, 0, 1, 0, 0, 0);
    tick(); clr();
    chk("lu_c1",           0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    chk("lu_c2_free",      0, 0, 0, 0, 0, 0, 0, 0);
    load_hazard(); rd_exe = 0; rs1_id = 0;
    chk("lu_rd0",          0, 0, 0, 0, 0, 0, 0, 0);
    tick(); clr();
    chk("lu_rd0_next",     0, 0, 0, 0, 0, 0, 0, 0);
    mem_to_reg_exe = 1; rd_exe = 7; rs2_id = 7; rs2_used_id = 1;
    rs1_id = 7; rs1_used_id = 0;
    chk("lu_rs2",          0, 1, 1, 0, 1, 0, 0, 0);
    tick(); clr();
    chk("lu_rs2_c1",       0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    load_hazard(); rs1_used_id = 0;
    chk("lu_unused_src",   0, 0, 0, 0, 0, 0, 0, 0);
    clr(); rd_exe = 5; rs1_id = 5; rs1_used_id = 1;
    chk("no_load_match",   0, 0, 0, 0, 0, 0, 0, 0);
    tick(); clr();

    // Branch evaluation
    branch_mem = 1; fun3_mem = 3'b101; less_mem = 0;
    chk("bge_taken",       1, 0, 0, 1, 1, 1, 0, 0);
    less_mem = 1;
    chk("bge_not_taken",   0, 0, 0, 0, 0, 0, 0, 0);
    fun3_mem = 3'b010; zero_mem = 1; less_mem = 1; less_u_mem = 1;
    chk("f3_010_never",    0, 0, 0, 0, 0, 0, 0, 0);
    fun3_mem = 3'b011; zero_mem = 0; less_mem = 0; less_u_mem = 0;
    chk("f3_011_never",    0, 0, 0, 0, 0, 0, 0, 0);
    fun3_mem = 3'b000; zero_mem = 1;
    chk("beq_taken",       1, 0, 0, 1, 1, 1, 0, 0);
    fun3_mem = 3'b001;
    chk("bne_not_taken",   0, 0, 0, 0, 0, 0, 0, 0);
    fun3_mem = 3'b110; less_u_mem = 1;
    chk("bltu_taken",      1, 0, 0, 1, 1, 1, 0, 0);
    fun3_mem = 3'b111;
    chk("bgeu_not_taken",  0, 0, 0, 0, 0, 0, 0, 0);
    fun3_mem = 3'b100; less_mem = 1;
    chk("blt_taken",       1, 0, 0, 1, 1, 1, 0, 0);
    branch_mem = 0;
    chk("no_branch_flag",  0, 0, 0, 0, 0, 0, 0, 0);
    tick(); clr();

    // Hazard dropped under redirect
    load_hazard(); jump_mem = 1;
    chk("haz_in_redirect", 1, 0, 0, 1, 1, 1, 0, 0);
    tick(); clr();
    chk("haz_dropped",     0, 0, 0, 0, 0, 0, 0, 0);

    // mret outside handler
    mret_mem = 1;
    chk("mret_idle",       3, 0, 0, 1, 1, 1, 0, 0);
    tick(); clr();
    chk("mret_idle_after", 0, 0, 0, 0, 0, 0, 0, 0);

    // Interrupt waits for load-use stall
    load_hazard(); interrupt = 1; irq_enable = 1;
    chk("irq_lu_c0",       0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    mem_to_reg_exe = 0; rd_exe = 0; rs1_id = 0; rs1_used_id = 0;
    chk("irq_lu_c1",       0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    chk("irq_trap",        2, 0, 0, 1, 1, 1, 1, 0);
    tick();
    chk("handler_entered", 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("nested_ignored",  0, 0, 0, 0, 0, 0, 0, 1);
    interrupt = 0; mret_mem = 1;
    chk("mret_handler",    3, 0, 0, 1, 1, 1, 0, 1);
    tick(); clr();
    chk("handler_exit",    0, 0, 0, 0, 0, 0, 0, 0);

    // ext_stall against redirect and pending trap
    interrupt = 1; irq_enable = 1; jump_mem = 1;
    chk("pend_by_jump",    1, 0, 0, 1, 1, 1, 0, 0);
    tick();
    ext_stall = 1;
    chk("ext_stall_c0",    0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("ext_stall_c1",    0, 1, 1, 0, 0, 0, 0, 0);
    ext_stall = 0;
    chk("redirect_first",  1, 0, 0, 1, 1, 1, 0, 0);
    tick();
    jump_mem = 0;
    chk("trap_after",      2, 0, 0, 1, 1, 1, 1, 0);
    tick();
    interrupt = 0; mret_mem = 1; ext_stall = 1;
    chk("mret_stalled",    0, 1, 1, 0, 0, 0, 0, 1);
    tick();
    chk("mret_held",       0, 1, 1, 0, 0, 0, 0, 1);
    ext_stall = 0;
    chk("mret_released",   3, 0, 0, 1, 1, 1, 0, 1);
    tick(); clr();
    chk("exit_after_ext",  0, 0, 0, 0, 0, 0, 0, 0);

    // Withdrawn request
    interrupt = 1; irq_enable = 1; jump_mem = 1;
    chk("wd_blocked",      1, 0, 0, 1, 1, 1, 0, 0);
    tick(); clr(); irq_enable = 1;
    chk("wd_pend_no_trap", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wd_idle",         0, 0, 0, 0, 0, 0, 0, 0);
    interrupt = 1; irq_enable = 0;
    tick(); tick();
    chk("irq_masked",      0, 0, 0, 0, 0, 0, 0, 0);
    clr(); tick();

    // Reset in HANDLER with a live stall count
    interrupt = 1; irq_enable = 1;
    tick();
    chk("rst_pre_trap",    2, 0, 0, 1, 1, 1, 1, 0);
    tick(); clr();
    load_hazard();
    chk("rst_pre_stall",   0, 1, 1, 0, 1, 0, 0, 1);
    tick(); clr();
    chk("rst_cnt_live",    0, 1, 1, 0, 1, 0, 0, 1);
    reset = 1;
    chk("rst_async",       0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0;
    chk("rst_release",     0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    interrupt = 1; irq_enable = 1;
    chk("rst_irq_idle",    0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_irq_trap",    2, 0, 0, 1, 1, 1, 1, 0);
    tick(); clr();
    chk("rst_handler",     0, 0, 0, 0, 0, 0, 0, 1);
    mret_mem = 1;
    tick(); clr();
    chk("rst_final_idle",  0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central hazard/flush/trap controller for the 5-stage integer pipeline (IF/ID/EXE/MEM/WB). It resolves branches and jumps in MEM and redirects the PC. It inserts load-use bubbles over a parametrised load latency and freezes the pipe on external memory stalls. It sequences interrupt entry and mret exit through a small FSM that blocks nested traps.

Parameters:
REG_ADDR_W, 5, register-index width for rs/rd comparisons
LOAD_STALL_CYCLES, 1, bubbles per load-use hazard (legal 1..4)
CNT_W, 2, stall counter width; must satisfy 2**CNT_W >= LOAD_STALL_CYCLES

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
rs1_id  in  REG_ADDR_W  source 1 of the instruction in ID
rs2_id  in  REG_ADDR_W  source 2 of the instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
mem_to_reg_exe  in  1  EXE instruction is a load
rd_exe  in  REG_ADDR_W  destination register in EXE
branch_mem  in  1  conditional branch in MEM
jump_mem  in  1  jal/jalr in MEM
mret_mem  in  1  mret in MEM
fun3_mem  in  3  branch funct3 in MEM
zero_mem  in  1  ALU equal flag
less_mem  in  1  signed less-than flag
less_u_mem  in  1  unsigned less-than flag
interrupt  in  1  level interrupt request
irq_enable  in  1  mstatus.MIE
ext_stall  in  1  data/instruction memory wait
pc_sel  out  2  0 pc+4, 1 branch/jump target, 2 trap vector, 3 mepc
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_if_id  out  1  bubble into IF/ID
flush_id_exe  out  1  bubble into ID/EXE
flush_exe_mem  out  1  bubble into EXE/MEM
trap_take  out  1  one-cycle pulse: CSR saves mepc, PC takes vector
in_handler  out  1  trap in progress, nested traps blocked

Behaviour:
- Branch evaluation (combinational): funct3 000 taken = zero; 001 !zero; 100 less; 101 !less; 110 less_u; 111 !less_u; 010/011 never taken.
- redirect = jump_mem | (branch_mem & taken) | mret_mem.
- hazard_now = mem_to_reg_exe & rd_exe != 0 & ((rs1_used_id & rs1_id == rd_exe) | (rs2_used_id & rs2_id == rd_exe)).
- stall_cnt (CNT_W bits, reset 0):
  - Redirect → 0.
  - Else if !ext_stall, hazard_now and cnt == 0 → LOAD_STALL_CYCLES-1.
  - Else if !ext_stall and cnt != 0 → decrement.
- load_stall = hazard_now | (stall_cnt != 0).
- Priority (highest first): ext_stall > redirect > trap > load_stall > normal.
  - ext_stall: stall_if = stall_id = 1, every flush = 0, pc_sel = 0. FSM and counter hold.
  - redirect: pc_sel = 3 if mret_mem, else 1. flush_if_id = flush_id_exe = flush_exe_mem = 1. No stall.
  - trap: pc_sel = 2, all three flushes = 1, trap_take = 1.
  - load_stall: stall_if = stall_id = 1, flush_id_exe = 1, pc_sel = 0.
  - normal: all outputs 0.
- FSM states IDLE, PEND, HANDLER; reset → IDLE.
  - IDLE → PEND when interrupt & irq_enable.
  - PEND → IDLE if !(interrupt & irq_enable) (request withdrawn, no trap).
  - PEND: trap_take = 1 (Mealy, same cycle) when !ext_stall & !redirect & !load_stall; next state HANDLER. Otherwise stay in PEND.
  - HANDLER: in_handler = 1; interrupt ignored. Exit to IDLE on a non-stalled mret_mem redirect.
- mret_mem in IDLE/PEND still redirects with pc_sel = 3 but leaves the state unchanged.
- Reset mid-operation: stall_cnt = 0, FSM = IDLE, all outputs 0 while reset is asserted and the cycle after release, unless inputs request otherwise.
- Boundary cases:
  - rd_exe == 0 never stalls.
  - A hazard during a redirect cycle is dropped (the ID instruction is flushed).
  - LOAD_STALL_CYCLES = 1 means the counter is never loaded above 0.

Test Plan:
- Load to x5 in EXE, rs1_id = 5, rs1_used = 1, LOAD_STALL_CYCLES = 2 → stall_if/stall_id/flush_id_exe high for exactly 2 cycles, then 0; rd_exe = 0 with the same pattern → no stall.
- branch_mem = 1, fun3 = 101, less = 0 → pc_sel = 1 and 3 flushes for 1 cycle. fun3 = 101, less = 1 → pc_sel = 0, no flush. fun3 = 010 → never taken.
- interrupt = 1, irq_enable = 1 while a load-use stall is active → trap_take waits until the stall ends, then 1 pulse with pc_sel = 2; in_handler = 1 the next cycle. Second interrupt ignored; mret_mem → pc_sel = 3, in_handler = 0 the next cycle.
- ext_stall = 1 with jump_mem = 1 and PEND → stall_if/stall_id = 1, no flush, no trap_take. Drop ext_stall → redirect first; trap_take fires the following cycle.
- Interrupt pulsed for 1 cycle while a redirect blocks the trap, then withdrawn → FSM returns to IDLE, trap_take never asserts.
- Assert reset during HANDLER with stall_cnt = 1 → outputs 0 immediately, FSM = IDLE, stall_cnt = 0; a new interrupt after release traps normally.
